// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

  localparam int LANES = 16;
  localparam int XLEN  = 32;
  localparam int AW    = 4;

  localparam logic [AW-1:0] PC_REG = 4'd15;

  typedef logic [LANES*XLEN-1:0] lane_vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          vec;
    lane_vec_t     data;
  } wb_req_t;

  // r15 is the PC: scalar writes to it must never reach the register file.
  function automatic logic is_pc_write(input wb_req_t req);
    return (req.vec == 1'b0) && (req.addr == PC_REG);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester, stall and writeback signals of regfile_wb_arbiter.
// Perf counter wires exist only when REGFILE_WB_PERF_EN is defined.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic          alu_valid_i;
  logic          alu_ready_o;
  logic [AW-1:0] alu_addr_i;
  logic          alu_vec_i;
  lane_vec_t     alu_data_i;

  logic          mem_valid_i;
  logic          mem_ready_o;
  logic [AW-1:0] mem_addr_i;
  logic          mem_vec_i;
  lane_vec_t     mem_data_i;

  logic          stall_i;

  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic          wb_vec_o;
  lane_vec_t     wb_data_o;
  logic          err_r15_o;

`ifdef REGFILE_WB_PERF_EN
  logic [31:0]   perf_alu_cnt_o;
  logic [31:0]   perf_mem_cnt_o;
  logic [31:0]   perf_conflict_cnt_o;
`endif

  modport master (
    output alu_valid_i, alu_addr_i, alu_vec_i, alu_data_i,
    output mem_valid_i, mem_addr_i, mem_vec_i, mem_data_i,
    output stall_i,
    input  alu_ready_o, mem_ready_o,
    input  wb_we_o, wb_addr_o, wb_vec_o, wb_data_o, err_r15_o
`ifdef REGFILE_WB_PERF_EN
    , input perf_alu_cnt_o, perf_mem_cnt_o, perf_conflict_cnt_o
`endif
  );

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_vec_i, alu_data_i,
    input  mem_valid_i, mem_addr_i, mem_vec_i, mem_data_i,
    input  stall_i,
    output alu_ready_o, mem_ready_o,
    output wb_we_o, wb_addr_o, wb_vec_o, wb_data_o, err_r15_o
`ifdef REGFILE_WB_PERF_EN
    , output perf_alu_cnt_o, perf_mem_cnt_o, perf_conflict_cnt_o
`endif
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; req[0]/gnt[0] is the ALU, req[1]/gnt[1] the MEM port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio_r;

  // Combinational grant so ready can answer in the same cycle as valid.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_r ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // After any grant, priority moves to the requester that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (gnt[0]) begin
      prio_r <= 1'b1;
    end else if (gnt[1]) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Optional perf counters are built when REGFILE_WB_PERF_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic [1:0]    req_s;
  logic [1:0]    gnt_s;
  logic          acc_s;
  wb_req_t       alu_req_s;
  wb_req_t       mem_req_s;
  wb_req_t       sel_req_s;

  logic          wb_we_r;
  logic [AW-1:0] wb_addr_r;
  logic          wb_vec_r;
  lane_vec_t     wb_data_r;
  logic          err_r15_r;

  assign req_s     = {bus.mem_valid_i, bus.alu_valid_i};
  assign alu_req_s = {bus.alu_addr_i, bus.alu_vec_i, bus.alu_data_i};
  assign mem_req_s = {bus.mem_addr_i, bus.mem_vec_i, bus.mem_data_i};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_s),
    .en  (~bus.stall_i),
    .gnt (gnt_s)
  );

  assign bus.alu_ready_o = gnt_s[0];
  assign bus.mem_ready_o = gnt_s[1];
  assign acc_s           = |gnt_s;

  // Winning request fields.
  always_comb begin
    sel_req_s = alu_req_s;
    if (gnt_s[1]) begin
      sel_req_s = mem_req_s;
    end else begin
      sel_req_s = alu_req_s;
    end
  end

  // Output register; a dropped r15 write leaves addr/data untouched and only flags the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_r   <= 1'b0;
      wb_addr_r <= '0;
      wb_vec_r  <= 1'b0;
      wb_data_r <= '0;
      err_r15_r <= 1'b0;
    end else begin
      wb_we_r   <= 1'b0;
      err_r15_r <= 1'b0;
      if (acc_s) begin
        if (is_pc_write(sel_req_s)) begin
          err_r15_r <= 1'b1;
        end else begin
          wb_we_r   <= 1'b1;
          wb_addr_r <= sel_req_s.addr;
          wb_vec_r  <= sel_req_s.vec;
          wb_data_r <= sel_req_s.data;
        end
      end
    end
  end

  assign bus.wb_we_o   = wb_we_r;
  assign bus.wb_addr_o = wb_addr_r;
  assign bus.wb_vec_o  = wb_vec_r;
  assign bus.wb_data_o = wb_data_r;
  assign bus.err_r15_o = err_r15_r;

`ifdef REGFILE_WB_PERF_EN
  logic [31:0] perf_alu_r;
  logic [31:0] perf_mem_r;
  logic [31:0] perf_conf_r;

  // Accept and contention counters, free-running with natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_alu_r  <= 32'd0;
      perf_mem_r  <= 32'd0;
      perf_conf_r <= 32'd0;
    end else begin
      perf_alu_r  <= perf_alu_r + {31'd0, gnt_s[0]};
      perf_mem_r  <= perf_mem_r + {31'd0, gnt_s[1]};
      perf_conf_r <= perf_conf_r + {31'd0, (&req_s) & ~bus.stall_i};
    end
  end

  assign bus.perf_alu_cnt_o      = perf_alu_r;
  assign bus.perf_mem_cnt_o      = perf_mem_r;
  assign bus.perf_conflict_cnt_o = perf_conf_r;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors, a spec-level model and pinned literals.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int pin_id = 0;

  // Model state: expected outputs after the last accepted transfer.
  logic          m_prio = 1'b0;
  logic          e_we = 1'b0, e_err = 1'b0, e_vec = 1'b0;
  logic [AW-1:0] e_addr = '0;
  lane_vec_t     e_data = '0;
  int unsigned   m_alu_cnt = 0, m_mem_cnt = 0, m_conf_cnt = 0;
  int            gnt_log[$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tot = n_tot + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk or posedge rst) begin : cmp_blk
    logic          a_g, m_g;
    logic [AW-1:0] r_addr;
    logic          r_vec;
    lane_vec_t     r_data;
    logic [3:0]    seq;
    if (rst) begin
      m_prio = 1'b0; e_we = 1'b0; e_err = 1'b0; e_vec = 1'b0;
      e_addr = '0; e_data = '0;
      m_alu_cnt = 0; m_mem_cnt = 0; m_conf_cnt = 0;
      gnt_log.delete();
    end else begin
      chk("wb_we", bus.wb_we_o, e_we);
      chk("err_r15", bus.err_r15_o, e_err);
      chk("wb_addr", bus.wb_addr_o, e_addr);
      chk("wb_vec", bus.wb_vec_o, e_vec);
      chk("wb_data", bus.wb_data_o, e_data);
`ifdef REGFILE_WB_PERF_EN
      chk("perf_alu", bus.perf_alu_cnt_o, m_alu_cnt);
      chk("perf_mem", bus.perf_mem_cnt_o, m_mem_cnt);
      chk("perf_conf", bus.perf_conflict_cnt_o, m_conf_cnt);
`endif
      case (pin_id)
        1: begin
          chk("pin_vec_we", bus.wb_we_o, 1'b1);
          chk("pin_vec_addr", bus.wb_addr_o, 4'd3);
          chk("pin_vec_vec", bus.wb_vec_o, 1'b1);
          for (int k = 0; k < LANES; k++) chk("pin_lane", bus.wb_data_o[k*XLEN +: XLEN], 32'(k));
        end
        2: begin
          chk("pin_gnt_cnt", 32'(gnt_log.size()), 32'd4);
          seq = 4'b1111;
          for (int i = 0; i < 4 && i < gnt_log.size(); i++) seq[3-i] = gnt_log[i][0];
          chk("pin_gnt_order", seq, 4'b0101);
`ifdef REGFILE_WB_PERF_EN
          chk("pin_conf4", bus.perf_conflict_cnt_o, 32'd4);
`endif
        end
        3: begin
          chk("pin_r15_err", bus.err_r15_o, 1'b1);
          chk("pin_r15_we", bus.wb_we_o, 1'b0);
        end
        4: begin
          chk("pin_r14_we", bus.wb_we_o, 1'b1);
          chk("pin_r14_addr", bus.wb_addr_o, 4'd14);
          chk("pin_r14_vec", bus.wb_vec_o, 1'b0);
          chk("pin_r14_lane15", bus.wb_data_o[15*XLEN +: XLEN], 32'h12345678);
        end
`ifdef REGFILE_WB_PERF_EN
        5: begin
          chk("pin_perf_alu10", bus.perf_alu_cnt_o, 32'd10);
          chk("pin_perf_mem7", bus.perf_mem_cnt_o, 32'd7);
        end
`endif
        6: begin
          chk("pin_rst_alu_wins", bus.alu_ready_o, 1'b1);
          chk("pin_rst_mem_waits", bus.mem_ready_o, 1'b0);
        end
        7: begin
          chk("pin_stall_ready", bus.mem_ready_o, 1'b0);
          chk("pin_stall_we", bus.wb_we_o, 1'b0);
        end
        8: chk("pin_unstall_ready", bus.mem_ready_o, 1'b1);
        9: chk("pin_r15_ready", bus.alu_ready_o, 1'b1);
        10: chk("pin_rst_lost_we", bus.wb_we_o, 1'b0);
        default: ;
      endcase
      // Grant rules: stall blocks all, single valid wins, contention goes to prio.
      a_g = 1'b0; m_g = 1'b0;
      if (!bus.stall_i) begin
        if (bus.alu_valid_i && bus.mem_valid_i) begin
          m_conf_cnt++;
          if (m_prio) m_g = 1'b1; else a_g = 1'b1;
        end else if (bus.alu_valid_i) a_g = 1'b1;
        else if (bus.mem_valid_i) m_g = 1'b1;
      end
      chk("alu_ready", bus.alu_ready_o, a_g);
      chk("mem_ready", bus.mem_ready_o, m_g);
      e_we = 1'b0; e_err = 1'b0;
      if (a_g || m_g) begin
        if (a_g) begin
          r_addr = bus.alu_addr_i; r_vec = bus.alu_vec_i; r_data = bus.alu_data_i;
          m_alu_cnt++; gnt_log.push_back(0); m_prio = 1'b1;
        end else begin
          r_addr = bus.mem_addr_i; r_vec = bus.mem_vec_i; r_data = bus.mem_data_i;
          m_mem_cnt++; gnt_log.push_back(1); m_prio = 1'b0;
        end
        if (!r_vec && r_addr == 4'd15) e_err = 1'b1;
        else begin
          e_we = 1'b1; e_addr = r_addr; e_vec = r_vec; e_data = r_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid_i = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.stall_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    lane_vec_t tmp;
    idle();
    bus.alu_addr_i = 4'd0; bus.alu_vec_i = 1'b0; bus.alu_data_i = '0;
    bus.mem_addr_i = 4'd0; bus.mem_vec_i = 1'b0; bus.mem_data_i = '0;
    step(); step();
    rst = 1'b0;
    step();

    // ALU vector write, lane k = k
    for (int k = 0; k < LANES; k++) tmp[k*XLEN +: XLEN] = 32'(k);
    bus.alu_addr_i = 4'd3; bus.alu_vec_i = 1'b1; bus.alu_data_i = tmp;
    bus.alu_valid_i = 1'b1;
    step();
    idle(); pin_id = 1; step(); pin_id = 0;

    // Four cycles of contention straight after reset
    do_reset();
    for (int k = 0; k < LANES; k++) tmp[k*XLEN +: XLEN] = 32'hA000_0000 + 32'(k);
    bus.alu_addr_i = 4'd1; bus.alu_vec_i = 1'b1; bus.alu_data_i = tmp;
    for (int k = 0; k < LANES; k++) tmp[k*XLEN +: XLEN] = 32'hB000_0000 + 32'(k);
    bus.mem_addr_i = 4'd2; bus.mem_vec_i = 1'b1; bus.mem_data_i = tmp;
    bus.alu_valid_i = 1'b1; bus.mem_valid_i = 1'b1;
    repeat (4) step();
    idle(); pin_id = 2; step(); pin_id = 0;

    // MEM held off by stall for three cycles
    bus.mem_addr_i = 4'd6; bus.mem_vec_i = 1'b0; bus.mem_data_i = {32'hC0DE_0006, 480'd0};
    bus.mem_valid_i = 1'b1; bus.stall_i = 1'b1; pin_id = 7;
    repeat (3) step();
    bus.stall_i = 1'b0; pin_id = 8;
    step();
    idle(); pin_id = 0; step();

    // Scalar write to r15 is accepted but dropped; r14 issues
    bus.alu_addr_i = 4'd15; bus.alu_vec_i = 1'b0; bus.alu_data_i = {32'hDEADBEEF, 480'd0};
    bus.alu_valid_i = 1'b1; pin_id = 9;
    step();
    idle(); pin_id = 3; step(); pin_id = 0;
    bus.alu_addr_i = 4'd14; bus.alu_data_i = {32'h12345678, 480'd0};
    bus.alu_valid_i = 1'b1;
    step();
    idle(); pin_id = 4; step(); pin_id = 0;

    // Reset lands before the write is registered; prio returns to ALU
    bus.alu_addr_i = 4'd5; bus.alu_vec_i = 1'b1; bus.alu_data_i = {16{32'h5555_5555}};
    bus.alu_valid_i = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    idle(); rst = 1'b0; pin_id = 10;
    step();
    bus.mem_addr_i = 4'd7; bus.mem_vec_i = 1'b1;
    bus.alu_valid_i = 1'b1; bus.mem_valid_i = 1'b1; pin_id = 6;
    step();
    idle(); pin_id = 0; step();

    // 10 ALU then 7 MEM accepts from reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.alu_addr_i = 4'(i); bus.alu_vec_i = 1'b1; bus.alu_data_i = {16{32'(i)}};
      bus.alu_valid_i = 1'b1;
      step();
    end
    bus.alu_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_addr_i = 4'(i + 4); bus.mem_vec_i = 1'b0; bus.mem_data_i = {16{32'(i + 100)}};
      bus.mem_valid_i = 1'b1;
      step();
    end
    idle(); pin_id = 5; step(); pin_id = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
